// File: rtl/track_mem_arbiter.sv
// rtl/track_mem_arbiter.sv - round-robin arbiter sharing one track BRAM read port between two views
// Optional grant counters are enabled with TRACK_ARB_STATS_EN.
module track_mem_arbiter #(
   parameter int ADDR_W      = 17,
   parameter int DATA_W      = 12,
   parameter int MEM_LATENCY = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              a_req_in,
   input  logic [ADDR_W-1:0] a_addr_in,
   output logic              a_ready_out,
   output logic              a_rvalid_out,
   output logic [DATA_W-1:0] a_rdata_out,
   input  logic              b_req_in,
   input  logic [ADDR_W-1:0] b_addr_in,
   output logic              b_ready_out,
   output logic              b_rvalid_out,
   output logic [DATA_W-1:0] b_rdata_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic              mem_en_out,
   input  logic [DATA_W-1:0] mem_rdata_in
`ifdef TRACK_ARB_STATS_EN
   ,
   input  logic              frame_start_in,
   output logic [15:0]       a_grants_out,
   output logic [15:0]       b_grants_out
`endif
);

   localparam logic ID_A = 1'b0;
   localparam logic ID_B = 1'b1;

   logic                 last_grant_q;
   logic [MEM_LATENCY:0] tag_valid_q;
   logic [MEM_LATENCY:0] tag_id_q;
   logic                 accept_a;
   logic                 accept_b;
   logic                 accept;

   always_comb begin
      a_ready_out = 1'b0;
      b_ready_out = 1'b0;
      if (!rst_in) begin
         if (a_req_in && b_req_in) begin
            a_ready_out = (last_grant_q == ID_B);
            b_ready_out = (last_grant_q == ID_A);
         end else begin
            a_ready_out = a_req_in;
            b_ready_out = b_req_in;
         end
      end
   end

   assign accept_a = a_req_in & a_ready_out;
   assign accept_b = b_req_in & b_ready_out;
   assign accept   = accept_a | accept_b;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         last_grant_q <= ID_B;
         mem_en_out   <= 1'b0;
         mem_addr_out <= '0;
         tag_valid_q  <= '0;
         tag_id_q     <= '0;
      end else begin
         mem_en_out  <= accept;
         tag_valid_q <= {tag_valid_q[MEM_LATENCY-1:0], accept};
         tag_id_q    <= {tag_id_q[MEM_LATENCY-1:0], accept_b};
         if (accept) begin
            mem_addr_out <= accept_a ? a_addr_in : b_addr_in;
            last_grant_q <= accept_a ? ID_A : ID_B;
         end
      end
   end

   // Gating with rst_in keeps a read accepted before reset from surfacing during the reset cycle.
   assign a_rvalid_out = tag_valid_q[MEM_LATENCY] & (tag_id_q[MEM_LATENCY] == ID_A) & ~rst_in;
   assign b_rvalid_out = tag_valid_q[MEM_LATENCY] & (tag_id_q[MEM_LATENCY] == ID_B) & ~rst_in;
   assign a_rdata_out  = mem_rdata_in;
   assign b_rdata_out  = mem_rdata_in;

`ifdef TRACK_ARB_STATS_EN
   always_ff @(posedge clk_in) begin
      if (rst_in || frame_start_in) begin
         a_grants_out <= '0;
         b_grants_out <= '0;
      end else begin
         if (accept_a && a_grants_out != 16'hFFFF) a_grants_out <= a_grants_out + 16'd1;
         if (accept_b && b_grants_out != 16'hFFFF) b_grants_out <= b_grants_out + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_track_mem_arbiter.sv
// tb/tb_track_mem_arbiter.sv - directed and random checks of track_mem_arbiter against a transaction model
module tb_track_mem_arbiter;
   localparam int AW = 17;
   localparam int DW = 12;
   localparam int LAT = 3;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          a_req_in, b_req_in;
   logic [AW-1:0] a_addr_in, b_addr_in;
   logic          a_ready_out, b_ready_out, a_rvalid_out, b_rvalid_out;
   logic [DW-1:0] a_rdata_out, b_rdata_out;
   logic [AW-1:0] mem_addr_out;
   logic          mem_en_out;
   logic [DW-1:0] mem_rdata_in;
   logic          frame_start_in;
`ifdef TRACK_ARB_STATS_EN
   logic [15:0]   a_grants_out, b_grants_out;
`endif

   track_mem_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .a_req_in(a_req_in), .a_addr_in(a_addr_in), .a_ready_out(a_ready_out),
      .a_rvalid_out(a_rvalid_out), .a_rdata_out(a_rdata_out),
      .b_req_in(b_req_in), .b_addr_in(b_addr_in), .b_ready_out(b_ready_out),
      .b_rvalid_out(b_rvalid_out), .b_rdata_out(b_rdata_out),
      .mem_addr_out(mem_addr_out), .mem_en_out(mem_en_out), .mem_rdata_in(mem_rdata_in)
`ifdef TRACK_ARB_STATS_EN
      , .frame_start_in(frame_start_in), .a_grants_out(a_grants_out), .b_grants_out(b_grants_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [DW-1:0] texel(input logic [AW-1:0] addr);
      return addr[11:0] ^ {7'd0, addr[16:12]} ^ 12'h5A5;
   endfunction

   // Two-cycle synchronous-read BRAM.
   logic [DW-1:0] bram_s1;
   always_ff @(posedge clk_in) begin
      bram_s1      <= texel(mem_addr_out);
      mem_rdata_in <= bram_s1;
   end

   typedef struct {
      logic          id;
      logic [AW-1:0] addr;
      int            due;
   } ret_t;

   ret_t          pend[$];
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   logic          last_b = 1'b1;
   logic          exp_en = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   int            exp_a_cnt = 0;
   int            exp_b_cnt = 0;
   int            a_accepts = 0;
   int            b_accepts = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input logic ra, input logic [AW-1:0] aa, input logic rb,
                       input logic [AW-1:0] ab, input logic rs, input logic fs);
      logic ga, gb, ev_a, ev_b;
      @(negedge clk_in);
      a_req_in = ra; a_addr_in = aa; b_req_in = rb; b_addr_in = ab;
      rst_in = rs; frame_start_in = fs;
      #1;
      if (rs) begin ga = 0; gb = 0; end
      else if (ra && rb) begin ga = last_b; gb = !last_b; end
      else begin ga = ra; gb = rb; end
      check("a_ready", a_ready_out, ga);
      check("b_ready", b_ready_out, gb);
      check("mem_en", mem_en_out, exp_en);
      check("mem_addr", mem_addr_out, exp_addr);
      ev_a = 0; ev_b = 0;
      if (pend.size() > 0 && pend[0].due == cyc && !rs) begin
         ev_a = (pend[0].id == 1'b0);
         ev_b = (pend[0].id == 1'b1);
         check(ev_a ? "a_rdata" : "b_rdata", ev_a ? a_rdata_out : b_rdata_out, texel(pend[0].addr));
      end
      check("a_rvalid", a_rvalid_out, ev_a);
      check("b_rvalid", b_rvalid_out, ev_b);
      if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
`ifdef TRACK_ARB_STATS_EN
      check("a_grants", a_grants_out, exp_a_cnt);
      check("b_grants", b_grants_out, exp_b_cnt);
`endif
      if (rs) begin
         pend.delete();
         exp_en = 0; exp_addr = '0; last_b = 1;
         exp_a_cnt = 0; exp_b_cnt = 0;
      end else begin
         exp_en = ga | gb;
         if (ga | gb) begin
            exp_addr = ga ? aa : ab;
            last_b = gb;
            pend.push_back('{id: gb, addr: exp_addr, due: cyc + LAT});
         end
         a_accepts += ga; b_accepts += gb;
         if (fs) begin exp_a_cnt = 0; exp_b_cnt = 0; end
         else begin
            if (ga && exp_a_cnt < 65535) exp_a_cnt++;
            if (gb && exp_b_cnt < 65535) exp_b_cnt++;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0);
   endtask

   initial begin
      rst_in = 1; a_req_in = 0; b_req_in = 0; a_addr_in = '0; b_addr_in = '0; frame_start_in = 0;
      repeat (2) @(posedge clk_in);

      // Single A read
      step(1, 17'h00010, 0, '0, 0, 0);
      idle(4);

      // Continuous contention alternates A,B
      for (int i = 0; i < 6; i++) step(1, 17'h00100, 1, 17'h00200, 0, 0);
      idle(4);
      check("alternate_a_count", a_accepts, 4);
      check("alternate_b_count", b_accepts, 3);

      // B streams alone, then A joins
      for (int i = 0; i < 4; i++) step(0, '0, 1, 17'h00300 + 17'(i), 0, 0);
      for (int i = 0; i < 2; i++) step(1, 17'h00400, 1, 17'h00500, 0, 0);
      idle(4);

      // Reset with reads in flight
      for (int i = 0; i < 3; i++) step(1, 17'h01000 + 17'(i), 0, '0, 0, 0);
      step(1, 17'h01FFF, 1, 17'h02FFF, 1, 0);
      idle(5);

      // A raises then drops while B holds the grant
      step(1, 17'h0A000, 0, '0, 0, 0);
      step(1, 17'h0A001, 1, 17'h0B000, 0, 0);
      step(0, '0, 1, 17'h0B001, 0, 0);
      step(1, 17'h0A002, 1, 17'h0B002, 0, 0);
      idle(4);

      // Random traffic with occasional reset
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom),
              ($urandom_range(0, 39) == 0), 0);
      idle(4);
      check("pending_drained", pend.size(), 0);

`ifdef TRACK_ARB_STATS_EN
      for (int i = 0; i < 70000; i++) step(1, AW'(i), 0, '0, 0, 0);
      idle(1);
      check("a_grants_saturated", exp_a_cnt, 65535);
      step(0, '0, 0, '0, 0, 1);
      idle(1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
